// File: rtl/elevator_logic_if.sv
// rtl/elevator_logic_if.sv - ride request and car indicator bundle for elevator_logic
interface elevator_logic_if;
   logic       request_i;
   logic [3:0] requested_current_floor_i;
   logic [3:0] requested_destination_floor_i;
   logic [3:0] floor_o;
   logic [1:0] direction_o;
   logic       request_served_o;

   modport master (
      output request_i, requested_current_floor_i, requested_destination_floor_i,
      input  floor_o, direction_o, request_served_o
   );

   modport slave (
      input  request_i, requested_current_floor_i, requested_destination_floor_i,
      output floor_o, direction_o, request_served_o
   );
endinterface

// File: rtl/elevator_logic.sv
// rtl/elevator_logic.sv - single-car elevator controller serving one ride at a time
module elevator_logic #(
   parameter int MAXFLOORS    = 10,
   parameter int MINFLOORS    = 0,
   parameter int FLOOR_CYCLES = 4,
   parameter int DOOR_CYCLES  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   elevator_logic_if.slave   bus
);
   localparam int CMAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      IDLE, MOVE_PICK, DOOR_PICK, MOVE_DEST, DOOR_DEST, SERVED
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    floor_q, floor_d;
   logic [3:0]    target_q, target_d;
   logic [3:0]    dest_q, dest_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          pick_ok, dest_ok, moving;

   // int compare keeps the range check well-defined for any MINFLOORS, including 0
   assign pick_ok = (int'(bus.requested_current_floor_i) >= MINFLOORS) &&
                    (int'(bus.requested_current_floor_i) <= MAXFLOORS);
   assign dest_ok = (int'(bus.requested_destination_floor_i) >= MINFLOORS) &&
                    (int'(bus.requested_destination_floor_i) <= MAXFLOORS);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         floor_q  <= 4'(MINFLOORS);
         target_q <= 4'(MINFLOORS);
         dest_q   <= 4'(MINFLOORS);
         cnt_q    <= '0;
         armed_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         target_q <= target_d;
         dest_q   <= dest_d;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      target_d = target_q;
      dest_d   = dest_q;
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      if (!bus.request_i) armed_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (bus.request_i && armed_q && pick_ok && dest_ok) begin
               target_d = bus.requested_current_floor_i;
               dest_d   = bus.requested_destination_floor_i;
               cnt_d    = '0;
               armed_d  = 1'b0;
               state_d  = MOVE_PICK;
            end
         end
         MOVE_PICK, MOVE_DEST: begin
            if (floor_q == target_q) begin
               cnt_d   = '0;
               state_d = (state_q == MOVE_PICK) ? DOOR_PICK : DOOR_DEST;
            end else if (cnt_q == CW'(FLOOR_CYCLES - 1)) begin
               cnt_d   = '0;
               floor_d = (target_q > floor_q) ? floor_q + 4'd1 : floor_q - 4'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DOOR_PICK, DOOR_DEST: begin
            if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
               cnt_d = '0;
               if (state_q == DOOR_PICK) begin
                  target_d = dest_q;
                  state_d  = MOVE_DEST;
               end else begin
                  state_d = SERVED;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SERVED:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign moving = (state_q == MOVE_PICK) || (state_q == MOVE_DEST);

   assign bus.floor_o          = floor_q;
   assign bus.request_served_o = (state_q == SERVED);
   assign bus.direction_o      = !moving              ? 2'b00 :
                                 (target_q > floor_q) ? 2'b01 :
                                 (target_q < floor_q) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_elevator_logic.sv
// tb/tb_elevator_logic.sv - randomized self-checking bench for elevator_logic
module tb_elevator_logic;
   localparam int MAXF = 10;
   localparam int MINF = 0;
   localparam int FC   = 4;
   localparam int DC   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_floor = MINF;

   elevator_logic_if bus ();

   elevator_logic #(
      .MAXFLOORS(MAXF), .MINFLOORS(MINF), .FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int dcode(input int v);
      return (v > 0) ? 1 : (v < 0) ? 2 : 0;
   endfunction

   function automatic int ride_len(input int f0, input int p, input int d);
      return FC * (iabs(p - f0) + iabs(d - p)) + 2 + 2 * DC;
   endfunction

   // Expected outputs k edges after the accepting edge, derived from the ride timeline
   function automatic void ride_model(input int f0, input int p, input int d, input int k,
                                      output int ef, output int edir, output int esrv);
      int d1, d2, s1, s2, k0, j;
      d1 = iabs(p - f0);
      d2 = iabs(d - p);
      s1 = (p > f0) ? 1 : (p < f0) ? -1 : 0;
      s2 = (d > p) ? 1 : (d < p) ? -1 : 0;
      k0 = FC * d1 + 1 + DC;
      esrv = (k == ride_len(f0, p, d)) ? 1 : 0;
      if (k <= FC * d1) begin
         ef   = f0 + s1 * (k / FC);
         edir = (k < FC * d1) ? dcode(s1) : 0;
      end else if (k < k0) begin
         ef   = p;
         edir = 0;
      end else if (k - k0 <= FC * d2) begin
         j    = k - k0;
         ef   = p + s2 * (j / FC);
         edir = (j < FC * d2) ? dcode(s2) : 0;
      end else begin
         ef   = d;
         edir = 0;
      end
   endfunction

   task automatic check_idle(input string tag, input int f);
      chk({tag, ".floor"}, bus.floor_o, f);
      chk({tag, ".dir"}, bus.direction_o, 0);
      chk({tag, ".served"}, bus.request_served_o, 0);
   endtask

   task automatic ride(input int p, input int d, input int hold);
      int ef, edir, esrv, len, pulses;
      len    = ride_len(cur_floor, p, d);
      pulses = 0;
      bus.requested_current_floor_i     = 4'(p);
      bus.requested_destination_floor_i = 4'(d);
      bus.request_i                     = 1'b1;
      for (int k = 0; k <= len; k++) begin
         @(posedge clk); #1;
         ride_model(cur_floor, p, d, k, ef, edir, esrv);
         chk("ride.floor", bus.floor_o, ef);
         chk("ride.dir", bus.direction_o, edir);
         chk("ride.served", bus.request_served_o, esrv);
         if (bus.request_served_o === 1'b1) pulses++;
      end
      chk("ride.pulses", pulses, 1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_idle("hold", d);
      end
      bus.request_i = 1'b0;
      @(posedge clk); #1;
      check_idle("post", d);
      cur_floor = d;
   endtask

   task automatic bad_request(input int p, input int d, input int cycles);
      bus.requested_current_floor_i     = 4'(p);
      bus.requested_destination_floor_i = 4'(d);
      bus.request_i                     = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         check_idle("oor", cur_floor);
      end
      bus.request_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ride_abort(input int p, input int d, input int at_floor);
      int ef, edir, esrv, k;
      bus.requested_current_floor_i     = 4'(p);
      bus.requested_destination_floor_i = 4'(d);
      bus.request_i                     = 1'b1;
      k  = 0;
      ef = cur_floor;
      while (ef != at_floor && k < 200) begin
         @(posedge clk); #1;
         ride_model(cur_floor, p, d, k, ef, edir, esrv);
         chk("abort.floor", bus.floor_o, ef);
         chk("abort.dir", bus.direction_o, edir);
         k++;
      end
      rst           = 1'b1;
      bus.request_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("abort.rst", MINF);
      for (int c = 0; c < ride_len(cur_floor, p, d); c++) begin
         @(posedge clk); #1;
         check_idle("abort.after", MINF);
      end
      cur_floor = MINF;
   endtask

   initial begin
      int p, d;
      bus.request_i                     = 1'b0;
      bus.requested_current_floor_i     = '0;
      bus.requested_destination_floor_i = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check_idle("reset", MINF);
      end

      ride(4, 8, 5);
      bad_request(4, 12, 8);
      bad_request(11, 2, 8);
      ride(3, 3, 0);
      ride(3, 8, 0);
      ride(2, 0, 0);
      ride(0, 0, 1);
      ride_abort(5, 9, 5);

      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 0) bad_request(int'($urandom_range(11, 15)), int'($urandom_range(0, 10)), 4);
            else                           bad_request(int'($urandom_range(0, 10)), int'($urandom_range(11, 15)), 4);
         end else begin
            p = int'($urandom_range(MINF, MAXF));
            d = int'($urandom_range(MINF, MAXF));
            ride(p, d, int'($urandom_range(0, 2)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
